// File: rtl/camera_frame_packer.sv
// camera_frame_packer: samples the OV7670 byte stream on PCLK, packs byte
// pairs into RGB565 pixels and writes a tagged 17-bit word stream (start
// frame, start row, pixel, end frame) into the capture FIFO. Frame geometry
// and FIFO overflow are reported through sticky status flags.
module camera_frame_packer #(
   parameter int FRAME_WIDTH  = 640,
   parameter int FRAME_HEIGHT = 480
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        vsync,
   input  logic        href,
   input  logic [7:0]  cam_data,
   input  logic        fifo_full,
   output logic        fifo_wr_en,
   output logic [16:0] fifo_data,
   output logic        frame_done,
   output logic        overflow,
   output logic        geom_err,
   input  logic        clear_status
);

   localparam logic [16:0] WORD_SOF = 17'h10000;
   localparam logic [16:0] WORD_SOR = 17'h10001;
   localparam logic [16:0] WORD_EOF = 17'h1FFFF;
   localparam logic [10:0] COL_MAX  = 11'h7FF;
   localparam logic [9:0]  ROW_MAX  = 10'h3FF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_VSYNC,
      S_WAIT_VSYNC_LOW,
      S_WAIT_ROW,
      S_ROW_LO,
      S_ROW_HI,
      S_FRAME_END
   } state_t;

   state_t      state_r, state_nxt_s;
   logic        vs_r, hr_r, vs_d_r, hr_d_r;
   logic [7:0]  d_r, hi_r;
   logic [10:0] col_cnt_r;
   logic [9:0]  row_cnt_r;
   logic        skip_frame_r;

   logic        vs_rise_s, vs_fall_s, hr_rise_s;
   logic        col_bad_s, row_bad_s;
   logic        emit_s, droppable_s, end_word_s;
   logic [16:0] word_s;
   logic        hi_load_s, col_clr_s, col_inc_s, row_clr_s, row_inc_s, geom_set_s;
   logic        attempt_s, wr_s, ovf_set_s;

   assign vs_rise_s = vs_r & ~vs_d_r;
   assign vs_fall_s = ~vs_r & vs_d_r;
   assign hr_rise_s = hr_r & ~hr_d_r;

   // A saturated counter can no longer prove the geometry, so it always mismatches.
   assign col_bad_s = (col_cnt_r == COL_MAX) || (col_cnt_r != 11'(FRAME_WIDTH));
   assign row_bad_s = (row_cnt_r == ROW_MAX) || (row_cnt_r != 10'(FRAME_HEIGHT));

   // Once a frame has lost a word, only the end-frame word is still attempted.
   assign attempt_s = emit_s & ~(droppable_s & skip_frame_r);
   assign wr_s      = attempt_s & ~fifo_full;
   assign ovf_set_s = attempt_s & fifo_full;

   // Input stage: one register on the camera pins plus a delayed copy for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         vs_r   <= 1'b0;
         hr_r   <= 1'b0;
         d_r    <= 8'h00;
         vs_d_r <= 1'b0;
         hr_d_r <= 1'b0;
      end else begin
         vs_r   <= vsync;
         hr_r   <= href;
         d_r    <= cam_data;
         vs_d_r <= vs_r;
         hr_d_r <= hr_r;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state decode and per-cycle emit / counter strobes.
   always_comb begin
      state_nxt_s = state_r;
      emit_s      = 1'b0;
      droppable_s = 1'b0;
      end_word_s  = 1'b0;
      word_s      = 17'h00000;
      hi_load_s   = 1'b0;
      col_clr_s   = 1'b0;
      col_inc_s   = 1'b0;
      row_clr_s   = 1'b0;
      row_inc_s   = 1'b0;
      geom_set_s  = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (enable) begin
               state_nxt_s = S_WAIT_VSYNC;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_WAIT_VSYNC: begin
            if (vs_r) begin
               state_nxt_s = S_WAIT_VSYNC_LOW;
            end else begin
               state_nxt_s = S_WAIT_VSYNC;
            end
         end
         S_WAIT_VSYNC_LOW: begin
            if (vs_fall_s) begin
               emit_s      = 1'b1;
               word_s      = WORD_SOF;
               row_clr_s   = 1'b1;
               state_nxt_s = S_WAIT_ROW;
            end else begin
               state_nxt_s = S_WAIT_VSYNC_LOW;
            end
         end
         S_WAIT_ROW: begin
            if (vs_rise_s) begin
               state_nxt_s = S_FRAME_END;
            end else if (hr_rise_s) begin
               emit_s      = 1'b1;
               droppable_s = 1'b1;
               word_s      = WORD_SOR;
               hi_load_s   = 1'b1;
               col_clr_s   = 1'b1;
               state_nxt_s = S_ROW_LO;
            end else begin
               state_nxt_s = S_WAIT_ROW;
            end
         end
         S_ROW_LO: begin
            if (vs_rise_s) begin
               geom_set_s  = 1'b1;
               state_nxt_s = S_FRAME_END;
            end else if (hr_r) begin
               emit_s      = 1'b1;
               droppable_s = 1'b1;
               word_s      = {1'b0, hi_r, d_r};
               col_inc_s   = 1'b1;
               state_nxt_s = S_ROW_HI;
            end else begin
               geom_set_s  = 1'b1;
               row_inc_s   = 1'b1;
               state_nxt_s = S_WAIT_ROW;
            end
         end
         S_ROW_HI: begin
            if (vs_rise_s) begin
               geom_set_s  = 1'b1;
               state_nxt_s = S_FRAME_END;
            end else if (hr_r) begin
               hi_load_s   = 1'b1;
               state_nxt_s = S_ROW_LO;
            end else begin
               geom_set_s  = col_bad_s;
               row_inc_s   = 1'b1;
               state_nxt_s = S_WAIT_ROW;
            end
         end
         S_FRAME_END: begin
            emit_s     = 1'b1;
            end_word_s = 1'b1;
            word_s     = WORD_EOF;
            geom_set_s = row_bad_s;
            if (enable) begin
               state_nxt_s = S_WAIT_VSYNC_LOW;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         default: begin
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // Datapath: high byte, saturating counters, registered FIFO port and sticky status.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hi_r         <= 8'h00;
         col_cnt_r    <= 11'd0;
         row_cnt_r    <= 10'd0;
         skip_frame_r <= 1'b0;
         fifo_wr_en   <= 1'b0;
         fifo_data    <= 17'h00000;
         frame_done   <= 1'b0;
         overflow     <= 1'b0;
         geom_err     <= 1'b0;
      end else begin
         if (hi_load_s) begin
            hi_r <= d_r;
         end
         if (col_clr_s) begin
            col_cnt_r <= 11'd0;
         end else if (col_inc_s && (col_cnt_r != COL_MAX)) begin
            col_cnt_r <= col_cnt_r + 11'd1;
         end
         if (row_clr_s) begin
            row_cnt_r <= 10'd0;
         end else if (row_inc_s && (row_cnt_r != ROW_MAX)) begin
            row_cnt_r <= row_cnt_r + 10'd1;
         end
         if (state_r == S_FRAME_END) begin
            skip_frame_r <= 1'b0;
         end else if (ovf_set_s) begin
            skip_frame_r <= 1'b1;
         end
         fifo_wr_en <= wr_s;
         if (wr_s) begin
            fifo_data <= word_s;
         end
         frame_done <= wr_s & end_word_s;
         overflow   <= ovf_set_s  | (overflow & ~clear_status);
         geom_err   <= geom_set_s | (geom_err & ~clear_status);
      end
   end

endmodule
